rr_arbiter_ctrl: RTL and testbench

- Round-robin arbiter and controller for a single shared resource used by WIDTH requesters.
- Issues a registered one-hot grant and holds it until the owner releases.
- Rotates a one-hot priority pointer so that the last owner becomes lowest priority.
- Sits between requester ports and the shared datapath; grant_id drives the datapath mux select.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_arbiter_ctrl_pick.sv | 27 ++
 rtl/rr_arbiter_ctrl.sv | 112 +++++++++++
 tb/tb_rr_arbiter_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM state, pointer rotate,
// one-hot to index conversion and the default requester count.
package arb_pkg;

  localparam int unsigned ARB_WIDTH = 4;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;

  // Rotate the low w bits of v left by one; bit w-1 wraps to bit 0.
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << 1) | (v >> (w - 1))) & m;
  endfunction

  function automatic int oh2idx(input logic [63:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_ctrl_pick.sv
// Combinational round-robin pick: first set (req & ~mask) bit at or above the
// one-hot prio bit, wrapping cyclically, found with a double-width scan.
module rr_pick #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] prio,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] win,
  output logic             any
);

  logic [WIDTH-1:0]   r;
  logic [2*WIDTH-1:0] dbl, thr, m, low;

  // Lower copy keeps bits at/above prio; the upper copy supplies the wrap-around.
  always_comb begin
    r   = req & ~mask;
    dbl = {r, r};
    thr = {{WIDTH{1'b0}}, prio} - {{(2*WIDTH-1){1'b0}}, 1'b1};
    m   = dbl & ~thr;
    low = m & (~m + {{(2*WIDTH-1){1'b0}}, 1'b1});
    win = low[WIDTH-1:0] | low[2*WIDTH-1:WIDTH];
    any = |r;
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter/controller for one shared resource with registered one-hot grant.
// Optional forced release after MAX_HOLD cycles is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH    = ARB_WIDTH,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         req,
  input  logic                     done,
  output logic [WIDTH-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(WIDTH)-1:0] grant_id,
  output logic [WIDTH-1:0]         prio,
  output logic                     preempt
);

  localparam int unsigned ID_W = $clog2(WIDTH);

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d, prio_q, prio_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             gv_q;
  logic [WIDTH-1:0] pick_prio, pick_mask, win;
  logic             any, rel, tmo, ld;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only preempt when someone else is waiting; a lone owner keeps the resource.
  assign tmo = (state_q == OWNED) && (cnt_q == CNT_W'(MAX_HOLD - 1)) && (|(req & ~grant_q));

  always_comb begin
    cnt_d = cnt_q;
    if (ld) cnt_d = '0;
    else if (state_q == OWNED && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign rel       = (state_q == OWNED) && (done || !req[id_q] || tmo);
  assign pick_prio = rel ? WIDTH'(rotl1(64'(grant_q), WIDTH)) : prio_q;
  assign pick_mask = rel ? grant_q : '0;

  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .req  (req),
    .prio (pick_prio),
    .mask (pick_mask),
    .win  (win),
    .any  (any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      id_q    <= '0;
      prio_q  <= WIDTH'(1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= |grant_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = OWNED;
      OWNED:   if (rel && !any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Release re-arbitrates in the same cycle so a waiting requester sees no bubble.
  always_comb begin
    grant_d = grant_q;
    id_d    = id_q;
    prio_d  = prio_q;
    ld      = 1'b0;
    if (state_q == IDLE && any) ld = 1'b1;
    if (rel) begin
      prio_d  = pick_prio;
      grant_d = '0;
      id_d    = '0;
      ld      = any;
    end
    if (ld) begin
      grant_d = win;
      id_d    = ID_W'(oh2idx(64'(win)));
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gv_q;
  assign grant_id    = id_q;
  assign prio        = prio_q;
  assign preempt     = tmo;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Directed bench for rr_arbiter_ctrl; timeout expectations follow ARB_TIMEOUT_EN.
module tb_rr_arbiter_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant, prio;
  logic       grant_valid, preempt;
  logic [1:0] grant_id;

  int n_chk = 0;
  int n_bad = 0;

  rr_arbiter_ctrl #(.WIDTH(4), .CNT_W(8), .MAX_HOLD(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .prio        (prio),
    .preempt     (preempt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] seq [5];
  int         pulses;

  initial begin
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    reset = 1'b1; req = '0; done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_id", 32'(grant_id), 0);
    chk("rst_prio", 32'(prio), 1);
    chk("rst_pre", 32'(preempt), 0);

    // single request, then done
    req = 4'b0100; tick();
    chk("t1_grant", 32'(grant), 32'b0100);
    chk("t1_id", 32'(grant_id), 2);
    chk("t1_gv", 32'(grant_valid), 1);
    done = 1'b1; tick();
    chk("t1_rel_grant", 32'(grant), 0);
    chk("t1_rel_prio", 32'(prio), 32'b1000);
    chk("t1_rel_gv", 32'(grant_valid), 0);
    done = 1'b0; req = '0; tick();
    done = 1'b1; tick();
    chk("idle_done", 32'(grant), 0);
    chk("idle_done_prio", 32'(prio), 32'b1000);
    done = 1'b0;

    // full rotation with done each tenure
    do_reset();
    req = 4'b1111; tick();
    chk("rot_0", 32'(grant), 32'(seq[0]));
    done = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("rot_%0d", i), 32'(grant), 32'(seq[i]));
      chk($sformatf("rot_gv_%0d", i), 32'(grant_valid), 1);
    end
    done = 1'b0; req = '0; tick();
    chk("drop_idle", 32'(grant), 0);
    chk("drop_prio", 32'(prio), 32'b0010);

    // owner 1 drops while 0 and 3 request
    req = 4'b0010; tick();
    chk("own1", 32'(grant), 32'b0010);
    req = 4'b1001; tick();
    chk("own1_drop_grant", 32'(grant), 32'b1000);
    chk("own1_drop_id", 32'(grant_id), 3);
    chk("own1_drop_prio", 32'(prio), 32'b0100);
    req = 4'b1111; tick();
    chk("hold_grant", 32'(grant), 32'b1000);
    chk("hold_prio", 32'(prio), 32'b0100);

    // lone requester 3: one idle cycle between tenures
    do_reset();
    req = 4'b1000; tick();
    chk("solo_grant", 32'(grant), 32'b1000);
    done = 1'b1; tick();
    chk("solo_bubble", 32'(grant), 0);
    chk("solo_prio", 32'(prio), 32'b0001);
    done = 1'b0; tick();
    chk("solo_regrant", 32'(grant), 32'b1000);
    chk("solo_id", 32'(grant_id), 3);

    // reset mid-tenure
    do_reset();
    req = 4'b0010; tick();
    chk("mid_grant", 32'(grant), 32'b0010);
    reset = 1'b1; tick();
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_prio", 32'(prio), 1);
    chk("mid_rst_gv", 32'(grant_valid), 0);
    chk("mid_rst_id", 32'(grant_id), 0);
    reset = 1'b0;

    // timeout behaviour with two requesters and no done
    do_reset();
    req = 4'b0011; tick();
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("to_grant_%0d", k), 32'(grant), 32'b0001);
`ifdef ARB_TIMEOUT_EN
      chk($sformatf("to_pre_%0d", k), 32'(preempt), (k == 15) ? 1 : 0);
`else
      chk($sformatf("to_pre_%0d", k), 32'(preempt), 0);
`endif
      if (preempt) pulses++;
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    chk("to_after", 32'(grant), 32'b0010);
    chk("to_pulses", 32'(pulses), 1);
`else
    for (int k = 0; k < 24; k++) begin
      if (preempt) pulses++;
      tick();
    end
    chk("to_after", 32'(grant), 32'b0001);
    chk("to_pulses", 32'(pulses), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
